// File: rtl/iob_axistream_pack.sv
// iob_axistream_pack: packs N = DATA_W/TDATA_W narrow AXI-Stream beats into
// one DATA_W-bit word with a contiguous lane strobe and a last flag.
// A one-word accumulator feeds a one-word output register so that a full
// word can be handed off while the next beat is written into lane 0.
module iob_axistream_pack #(
    parameter int TDATA_W = 8,
    parameter int DATA_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [TDATA_W-1:0]           s_tdata,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic                         s_tlast,
    input  logic                         flush,
    output logic [DATA_W-1:0]            m_data,
    output logic [DATA_W/TDATA_W-1:0]    m_strb,
    output logic                         m_last,
    output logic                         m_valid,
    input  logic                         m_ready
);

    localparam int N  = DATA_W / TDATA_W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [DATA_W-1:0] acc_reg, acc_next;
    logic [N-1:0]      acc_strb_reg, acc_strb_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic              acc_last_reg, acc_last_next;
    logic              pend_reg, pend_next;

    logic [DATA_W-1:0] m_data_reg;
    logic [N-1:0]      m_strb_reg;
    logic              m_last_reg;
    logic              m_valid_reg;

    logic accept;
    logic load;
    logic beat_done;
    logic flush_done;
    logic complete;

    // The output register takes the pending word whenever it is empty or
    // being drained this cycle; the accumulator can accept a beat when it is
    // not holding a finished word, or when that word leaves this cycle.
    assign load       = pend_reg & (~m_valid_reg | m_ready);
    assign s_tready   = rst & (~pend_reg | load);
    assign accept     = s_tvalid & s_tready;
    assign beat_done  = accept & ((idx_reg == IW'(N - 1)) | s_tlast);
    assign flush_done = flush & ~pend_reg & ((idx_reg != '0) | accept);
    assign complete   = beat_done | flush_done;

    // Per-lane next state: a written lane takes the beat, otherwise the lane
    // is cleared on hand-off or holds its value. While pend is set idx is 0,
    // so a beat arriving alongside a load lands in lane 0.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic lane_wr;
            assign lane_wr = accept & (idx_reg == IW'(gi));
            assign acc_next[gi*TDATA_W +: TDATA_W] =
                lane_wr ? s_tdata :
                (load ? '0 : acc_reg[gi*TDATA_W +: TDATA_W]);
            assign acc_strb_next[gi] = lane_wr | (~load & acc_strb_reg[gi]);
        end
    endgenerate

    // Lane index, completion flag and last flag of the accumulator.
    always_comb begin
        idx_next      = idx_reg;
        pend_next     = pend_reg & ~load;
        acc_last_next = acc_last_reg;
        if (complete) begin
            pend_next     = 1'b1;
            acc_last_next = accept & s_tlast;
            idx_next      = '0;
        end else if (accept) begin
            idx_next = idx_reg + IW'(1);
        end
    end

    // Accumulator state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_reg      <= '0;
            acc_strb_reg <= '0;
            idx_reg      <= '0;
            acc_last_reg <= 1'b0;
            pend_reg     <= 1'b0;
        end else begin
            acc_reg      <= acc_next;
            acc_strb_reg <= acc_strb_next;
            idx_reg      <= idx_next;
            acc_last_reg <= acc_last_next;
            pend_reg     <= pend_next;
        end
    end

    // Output word register: loads the pending word, otherwise drops valid
    // once consumed while keeping the data fields unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_data_reg  <= '0;
            m_strb_reg  <= '0;
            m_last_reg  <= 1'b0;
            m_valid_reg <= 1'b0;
        end else if (load) begin
            m_data_reg  <= acc_reg;
            m_strb_reg  <= acc_strb_reg;
            m_last_reg  <= acc_last_reg;
            m_valid_reg <= 1'b1;
        end else if (m_valid_reg & m_ready) begin
            m_valid_reg <= 1'b0;
        end
    end

    assign m_data  = m_data_reg;
    assign m_strb  = m_strb_reg;
    assign m_last  = m_last_reg;
    assign m_valid = m_valid_reg;

endmodule

// File: tb/tb_iob_axistream_pack.sv
// Testbench for iob_axistream_pack (TDATA_W=8, DATA_W=32): directed scenarios
// plus randomized traffic, checked against a queue-based packing model.
module tb_iob_axistream_pack;

    localparam int TW = 8;
    localparam int DW = 32;
    localparam int N  = DW / TW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [TW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] m_data;
    logic [N-1:0]  m_strb;
    logic          m_last;
    logic          m_valid;
    logic          m_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_words = 0;
    int out_cyc[$];

    typedef struct packed {
        logic [DW-1:0] d;
        logic [N-1:0]  s;
        logic          l;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] part_d = '0;
    int            part_n = 0;

    iob_axistream_pack #(.TDATA_W(TW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .flush(flush),
        .m_data(m_data), .m_strb(m_strb), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Close the model's partial word into the expected-word queue.
    task automatic close_word(input logic last);
        word_t w;
        w.d = part_d;
        w.s = N'((1 << part_n) - 1);
        w.l = last;
        exp_q.push_back(w);
        part_d = '0;
        part_n = 0;
    endtask

    // Monitor and reference model: handshakes are decided at the negedge
    // preceding the edge that commits them.
    initial begin
        word_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                part_d = '0;
                part_n = 0;
            end else begin
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_word: got 0x%0h, expected no word", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", {32'h0, m_data}, {32'h0, e.d});
                        check("m_strb", {60'h0, m_strb}, {60'h0, e.s});
                        check("m_last", {63'h0, m_last}, {63'h0, e.l});
                    end
                    n_words++;
                    out_cyc.push_back(cyc);
                end
                if (s_tvalid && s_tready) begin
                    part_d[part_n*TW +: TW] = s_tdata;
                    part_n++;
                    if (part_n == N || s_tlast) close_word(s_tlast);
                    else if (flush) close_word(1'b0);
                end else if (flush && part_n > 0) begin
                    close_word(1'b0);
                end
            end
        end
    end

    task automatic send_beat(input logic [TW-1:0] d, input logic l, output int stalls);
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        stalls   = 0;
        @(negedge clk);
        while (!s_tready && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (!s_tready) check("beat_accept_timeout", {63'h0, s_tready}, 64'h1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        flush    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int st;
        int stall_tot;
        int base;
        int b;
        logic took;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", {63'h0, m_valid}, 64'h0);
        check("rst_m_data", {32'h0, m_data}, 64'h0);
        check("rst_m_strb", {60'h0, m_strb}, 64'h0);
        check("rst_m_last", {63'h0, m_last}, 64'h0);
        @(negedge clk);
        check("rst_s_tready", {63'h0, s_tready}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        m_ready = 1'b1;

        // Full word with tlast and 2-cycle latency
        send_beat(8'h11, 1'b0, st);
        send_beat(8'h22, 1'b0, st);
        send_beat(8'h33, 1'b0, st);
        send_beat(8'h44, 1'b1, st);
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        @(negedge clk);
        check("lat_cycle1_valid", {63'h0, m_valid}, 64'h0);
        @(negedge clk);
        check("lat_cycle2_valid", {63'h0, m_valid}, 64'h1);
        check("t1_data", {32'h0, m_data}, 64'h44332211);
        check("t1_strb", {60'h0, m_strb}, 64'hF);
        check("t1_last", {63'h0, m_last}, 64'h1);
        idle(4);

        // Short packet
        send_beat(8'hAA, 1'b0, st);
        send_beat(8'hBB, 1'b1, st);
        idle(5);
        check("t2_data", {32'h0, m_data}, 64'h0000BBAA);
        check("t2_strb", {60'h0, m_strb}, 64'h3);
        check("t2_last", {63'h0, m_last}, 64'h1);

        // Flush of a partial word, then flush of an empty accumulator
        send_beat(8'h01, 1'b0, st);
        send_beat(8'h02, 1'b0, st);
        send_beat(8'h03, 1'b0, st);
        idle(1);
        base = n_words;
        pulse_flush();
        idle(5);
        check("flush_word_count", 64'(n_words - base), 64'd1);
        check("t3_data", {32'h0, m_data}, 64'h00030201);
        check("t3_strb", {60'h0, m_strb}, 64'h7);
        check("t3_last", {63'h0, m_last}, 64'h0);
        base = n_words;
        pulse_flush();
        idle(5);
        check("empty_flush_count", 64'(n_words - base), 64'd0);

        // Flush together with a beat
        base = n_words;
        flush = 1'b1;
        send_beat(8'h55, 1'b0, st);
        idle(5);
        check("flush_beat_count", 64'(n_words - base), 64'd1);
        check("flush_beat_strb", {60'h0, m_strb}, 64'h1);
        base = n_words;
        send_beat(8'h66, 1'b0, st);
        flush = 1'b1;
        send_beat(8'h77, 1'b1, st);
        idle(5);
        check("flush_tlast_count", 64'(n_words - base), 64'd1);
        check("flush_tlast_last", {63'h0, m_last}, 64'h1);

        // Sustained streaming with m_ready held high
        base = n_words;
        stall_tot = 0;
        for (int i = 0; i < 12; i++) begin
            send_beat(TW'(i), 1'b0, st);
            stall_tot += st;
        end
        idle(6);
        check("stream_stalls", 64'(stall_tot), 64'd0);
        check("stream_words", 64'(n_words - base), 64'd3);
        if (n_words - base >= 3) begin
            check("stream_gap1", 64'(out_cyc[base+1] - out_cyc[base]), 64'd4);
            check("stream_gap2", 64'(out_cyc[base+2] - out_cyc[base+1]), 64'd4);
        end

        // Backpressure: 8 beats fit, then the input stalls
        base = n_words;
        m_ready = 1'b0;
        b = 0;
        s_tdata = 8'h20;
        s_tvalid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            took = s_tready;
            @(posedge clk); #1;
            if (took) begin
                b++;
                s_tdata = TW'(8'h20 + b);
            end
        end
        check("stall_after_8", 64'(b), 64'd8);
        @(negedge clk);
        check("stall_tready_low", {63'h0, s_tready}, 64'h0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int c = 0; c < 100 && b < 12; c++) begin
            @(negedge clk);
            took = s_tready;
            @(posedge clk); #1;
            if (took) begin
                b++;
                s_tdata = TW'(8'h20 + b);
            end
            if (b == 12) s_tvalid = 1'b0;
        end
        idle(8);
        check("bp_beats", 64'(b), 64'd12);
        check("bp_words", 64'(n_words - base), 64'd3);

        // Reset in the middle of a word
        send_beat(8'hE1, 1'b0, st);
        send_beat(8'hE2, 1'b0, st);
        s_tvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_tready", {63'h0, s_tready}, 64'h0);
        @(posedge clk); #1;
        check("mid_rst_valid", {63'h0, m_valid}, 64'h0);
        check("mid_rst_data", {32'h0, m_data}, 64'h0);
        check("mid_rst_strb", {60'h0, m_strb}, 64'h0);
        check("mid_rst_last", {63'h0, m_last}, 64'h0);
        rst = 1'b1;
        base = n_words;
        send_beat(8'hA1, 1'b0, st);
        send_beat(8'hA2, 1'b0, st);
        send_beat(8'hA3, 1'b0, st);
        send_beat(8'hA4, 1'b0, st);
        idle(6);
        check("post_rst_words", 64'(n_words - base), 64'd1);
        check("post_rst_data", {32'h0, m_data}, 64'hA4A3A2A1);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            took = s_tvalid && s_tready;
            @(posedge clk); #1;
            m_ready = ($urandom % 4) != 0;
            if (!s_tvalid || took) begin
                s_tvalid = ($urandom % 3) != 0;
                s_tdata  = TW'($urandom);
                s_tlast  = ($urandom % 5) == 0;
            end
        end
        s_tvalid = 1'b0;
        m_ready = 1'b1;
        idle(6);
        pulse_flush();
        idle(8);
        check("drain_queue", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_axistream_pack.md
# iob_axistream_pack

AXI-Stream width packer. It sits directly downstream of the byte-wide AXI-Stream output peripheral and consumes its TDATA_W-bit stream (tdata/tvalid/tready/tlast). It packs N = DATA_W/TDATA_W beats into one DATA_W-bit word with a per-lane strobe and a last flag. A one-word accumulator and a one-word output register keep sustained throughput at one beat per cycle.

## Interface
- TDATA_W, 8: input beat width. Must be a multiple of 8 and must divide DATA_W.
- DATA_W, 32: output word width. N = DATA_W/TDATA_W is derived internally and is at least 1.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- s_tdata  in  TDATA_W  input beat.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  beat accepted when s_tvalid & s_tready.
- s_tlast  in  1  marks the final beat of a packet.
- flush  in  1  single-cycle request to emit a partially filled word.
- m_data  out  DATA_W  packed word; lane k is m_data[k*TDATA_W +: TDATA_W].
- m_strb  out  N  lane-valid mask; always contiguous ones from bit 0.
- m_last  out  1  word holds the final beat of a packet.
- m_valid  out  1  output word valid.
- m_ready  in  1  word consumed when m_valid & m_ready.

## Operation
- Accumulator state: acc (DATA_W), acc_strb (N), idx (0..N-1, width max(1,$clog2(N))), acc_last, pend.
- Beat accept (s_tvalid & s_tready):
  - acc lane idx <= s_tdata; acc_strb[idx] <= 1.
  - Completion occurs if idx==N-1 or s_tlast. Then pend <= 1, acc_last <= s_tlast, idx <= 0.
  - Otherwise idx <= idx+1.
- Flush: if flush, ~pend, and (idx>0 or a beat is accepted the same cycle), the word completes with acc_last <= s_tlast of that beat, or 0 if no beat. Flush with an empty accumulator and no beat is ignored.
- load = pend & (~m_valid | m_ready).
  - On load: m_data <= acc, m_strb <= acc_strb, m_last <= acc_last, m_valid <= 1.
  - On load, the accumulator clears (acc_strb <= 0, acc <= 0, pend <= 0) unless a new beat is written the same cycle. That beat lands in lane 0 of the cleared accumulator.
- m_valid & m_ready without load: m_valid <= 0. m_data, m_strb and m_last hold their last values.
- s_tready = rst & (~pend | load). This is combinational from m_ready, by design.
- Unused lanes of a partial word read 0.
- N==1: every accepted beat completes a word, with m_strb=1 and m_last=s_tlast.
- No data is ever dropped or reordered. Backpressure on m_ready propagates to s_tready within the same cycle once pend is set.

## Timing
- Reset (rst==0 at an edge) clears idx, acc, acc_strb, acc_last, pend, m_data, m_strb, m_last and m_valid to 0. s_tready is 0 while rst is low.
- Reset mid-operation discards both the partial word and the output word. No m_valid pulse follows reset.
- Latency: a completing beat accepted at edge t sets pend. If the output register is free, load happens at edge t+1 and m_valid is high after t+1. This is 2 cycles from the completing beat's acceptance to word visibility.
- Throughput: with m_ready held high, s_tready stays high continuously. One word per N beats is sustained, with no bubbles across word boundaries. This includes back-to-back tlast beats.
- Output full (m_valid & ~m_ready) with pend: s_tready=0 and the accumulator holds. When m_ready rises, load and a new beat accept occur in the same cycle.
- Simultaneous flush and completing beat: one completion only, with no extra empty word.
- Flush while pend=1: ignored, because the pending word is already complete.

## Test plan
- TDATA_W=8, DATA_W=32: send 0x11,0x22,0x33,0x44, with tlast on 0x44 and m_ready=1. Expect one word m_data=0x44332211, m_strb=4'b1111, m_last=1, with m_valid high 2 cycles after the 0x44 beat.
- Send 0xAA,0xBB with tlast on 0xBB. Expect m_data=0x0000BBAA, m_strb=4'b0011, m_last=1.
- Send 0x01,0x02,0x03, idle one cycle, then pulse flush. Expect m_data=0x00030201, m_strb=4'b0111, m_last=0. A second flush with an empty accumulator produces no word.
- Stream 12 beats 0x00..0x0B with m_ready=1. Expect s_tready high throughout and words 0x03020100, 0x07060504, 0x0B0A0908 on consecutive N-cycle spacing.
- Hold m_ready=0 while streaming 12 beats. Expect s_tready to drop after beat 8 (output word and pend both full). After m_ready=1, all three words arrive in order with none lost.
- Assert rst=0 for one cycle after 2 beats of a word. Expect all outputs 0 and s_tready=0 during reset. A subsequent 4-beat word packs from lane 0 with no residue.
